// File: rtl/pwm_multi_channel.sv
// N-channel PWM with button-driven per-channel duty, shadow/active duty registers that
// swap at period start, edge/center carrier, and debounced auto-repeating buttons.
module pwm_multi_channel #(
  parameter int CHANNELS        = 4,
  parameter int RESOLUTION_BITS = 8,
  parameter int FRECUENCY_BITS  = 3,
  parameter int DEBOUNCE_BITS   = 4,
  parameter int REPEAT_BITS     = 6,
  parameter int STEP            = 1
) (
  input  logic                         clk_top,
  input  logic                         rst_top,
  input  logic                         sum_top,
  input  logic                         rest_top,
  input  logic                         sel_top,
  input  logic                         mode_top,
  output logic [CHANNELS-1:0]          pwm_top,
  output logic [$clog2(CHANNELS)-1:0]  sel_chan,
  output logic [RESOLUTION_BITS-1:0]   duty_sel,
  output logic                         period_top,
  output logic                         rdy_top
);

  localparam int SW = $clog2(CHANNELS);
  localparam int RW = RESOLUTION_BITS;
  localparam int DW = DEBOUNCE_BITS + 1;
  localparam int NB = 3;
  localparam int BTN_SUM  = 0;
  localparam int BTN_REST = 1;
  localparam int BTN_SEL  = 2;

  localparam logic [RW-1:0]             MAX_DUTY  = '1;
  localparam logic [RW-1:0]             STEP_V    = RW'(STEP);
  localparam logic [RW-1:0]             CAR_ONE   = RW'(1);
  localparam logic [FRECUENCY_BITS-1:0] PRESC_ONE = FRECUENCY_BITS'(1);
  localparam logic [DW-1:0]             DEB_DONE  = DW'(1) << DEBOUNCE_BITS;
  localparam logic [DW-1:0]             DEB_ONE   = DW'(1);
  localparam logic [REPEAT_BITS-1:0]    REP_ONE   = REPEAT_BITS'(1);
  localparam logic [SW-1:0]             LAST_CHAN = SW'(CHANNELS - 1);
  localparam logic [SW-1:0]             SEL_ONE   = SW'(1);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  logic [NB-1:0]             sync1_q, sync1_d, sync2_q, sync2_d, fire_q, fire_d;
  logic [DW-1:0]             deb_cnt_q [NB];
  logic [DW-1:0]             deb_cnt_d [NB];
  logic [REPEAT_BITS-1:0]    rep_cnt_q [NB];
  logic [REPEAT_BITS-1:0]    rep_cnt_d [NB];
  logic [RW-1:0]             shadow_q  [CHANNELS];
  logic [RW-1:0]             shadow_d  [CHANNELS];
  logic [RW-1:0]             active_q  [CHANNELS];
  logic [RW-1:0]             active_d  [CHANNELS];
  logic [SW-1:0]             sel_q, sel_d;
  logic [FRECUENCY_BITS-1:0] presc_q, presc_d;
  logic [RW-1:0]             carrier_q, carrier_d, car_step, cur_duty, nxt_duty;
  dir_e                      dir_q, dir_d;
  logic                      mode_q, mode_d, period_q, period_d;
  logic                      changed_q, changed_d, rdy_q, rdy_d, tick;
  logic [CHANNELS-1:0]       pwm_q, pwm_d;

  // Each button: 2-flop sync, debounce to DEB_DONE, then a free-running repeat counter
  // whose wrap to zero marks every re-fire while the button stays held.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sync1_d   = {sel_top, rest_top, sum_top};
    sync2_d   = sync1_q;
    deb_cnt_d = deb_cnt_q;
    rep_cnt_d = rep_cnt_q;
    fire_d    = '0;
    for (int b = 0; b < NB; b++) begin
      if (sync2_q[b]) begin
        deb_cnt_d[b] = '0;
        rep_cnt_d[b] = '0;
      end else if (deb_cnt_q[b] != DEB_DONE) begin
        deb_cnt_d[b] = deb_cnt_q[b] + DEB_ONE;
      end else begin
        fire_d[b]    = (rep_cnt_q[b] == '0);
        rep_cnt_d[b] = rep_cnt_q[b] + REP_ONE;
      end
    end
  end

  // Duty and channel actions; the duty write always targets the pre-update channel.
  always_comb begin
    shadow_d = shadow_q;
    cur_duty = shadow_q[sel_q];
    nxt_duty = cur_duty;
    if (fire_q[BTN_SUM] && !fire_q[BTN_REST])
      nxt_duty = (cur_duty > MAX_DUTY - STEP_V) ? MAX_DUTY : cur_duty + STEP_V;
    else if (fire_q[BTN_REST] && !fire_q[BTN_SUM])
      nxt_duty = (cur_duty < STEP_V) ? '0 : cur_duty - STEP_V;
    shadow_d[sel_q] = nxt_duty;
    changed_d       = (nxt_duty != cur_duty);
    rdy_d           = changed_q;
    sel_d           = sel_q;
    if (fire_q[BTN_SEL])
      sel_d = (sel_q == LAST_CHAN) ? '0 : sel_q + SEL_ONE;
  end

  always_comb begin
    presc_d   = presc_q + PRESC_ONE;
    tick      = (presc_q == '1);
    car_step  = (mode_q && dir_q == DIR_DOWN) ? carrier_q - CAR_ONE : carrier_q + CAR_ONE;
    carrier_d = carrier_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    active_d  = active_q;
    period_d  = 1'b0;
    if (tick) begin
      carrier_d = car_step;
      if (mode_q && dir_q == DIR_UP && car_step == MAX_DUTY)
        dir_d = DIR_DOWN;
      // Returning to zero starts a new period: the only point duties and mode may change.
      if (car_step == '0) begin
        period_d = 1'b1;
        active_d = shadow_q;
        mode_d   = mode_top;
        dir_d    = DIR_UP;
      end
    end
    for (int i = 0; i < CHANNELS; i++)
      pwm_d[i] = (active_q[i] > carrier_q);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_top) begin
    if (rst_top) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      fire_q    <= '0;
      // NOTE: the duty arrays are ordinary flops and must be cleared element by element on reset.
      for (int b = 0; b < NB; b++) begin
        deb_cnt_q[b] <= '0;
        rep_cnt_q[b] <= '0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      sel_q     <= '0;
      presc_q   <= '0;
      carrier_q <= '0;
      dir_q     <= DIR_UP;
      mode_q    <= 1'b0;
      period_q  <= 1'b0;
      changed_q <= 1'b0;
      rdy_q     <= 1'b0;
      pwm_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      fire_q    <= fire_d;
      deb_cnt_q <= deb_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      sel_q     <= sel_d;
      presc_q   <= presc_d;
      carrier_q <= carrier_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      changed_q <= changed_d;
      rdy_q     <= rdy_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_top    = pwm_q;
  assign sel_chan   = sel_q;
  assign duty_sel   = shadow_q[sel_q];
  assign period_top = period_q;
  assign rdy_top    = rdy_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: a vector table of button presses with expected
// duty/channel/rdy counts, plus hand sequences for timing, PWM width and reset corners.
module tb_pwm_multi_channel;

  localparam int CH = 4;
  localparam int RB = 8;

  logic          clk_top  = 1'b0;
  logic          rst_top  = 1'b1;
  logic          sum_top  = 1'b1;
  logic          rest_top = 1'b1;
  logic          sel_top  = 1'b1;
  logic          mode_top = 1'b0;
  logic [CH-1:0] pwm_top;
  logic [1:0]    sel_chan;
  logic [RB-1:0] duty_sel;
  logic          period_top;
  logic          rdy_top;

  pwm_multi_channel #(
    .CHANNELS(CH), .RESOLUTION_BITS(RB), .FRECUENCY_BITS(1),
    .DEBOUNCE_BITS(2), .REPEAT_BITS(4), .STEP(1)
  ) dut (
    .clk_top(clk_top), .rst_top(rst_top), .sum_top(sum_top), .rest_top(rest_top),
    .sel_top(sel_top), .mode_top(mode_top), .pwm_top(pwm_top), .sel_chan(sel_chan),
    .duty_sel(duty_sel), .period_top(period_top), .rdy_top(rdy_top)
  );

  always #5 clk_top = ~clk_top;

  int n_vec     = 0;
  int n_bad     = 0;
  int rdy_total = 0;

  always @(negedge clk_top) if (rdy_top === 1'b1) rdy_total++;

  // btn: 0 sum, 1 rest, 2 sel, 3 sum+rest together
  typedef struct {
    int btn;
    int hold;
    int exp_duty;
    int exp_sel;
    int exp_rdy;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input int btn, input int hold, input int d, input int s, input int r);
    vec_t v;
    v.btn = btn; v.hold = hold; v.exp_duty = d; v.exp_sel = s; v.exp_rdy = r;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input int btn, input int n);
    @(posedge clk_top);
    #1;
    sum_top  = !(btn == 0 || btn == 3);
    rest_top = !(btn == 1 || btn == 3);
    sel_top  = !(btn == 2);
    repeat (n) @(posedge clk_top);
    #1;
    sum_top = 1'b1; rest_top = 1'b1; sel_top = 1'b1;
  endtask

  task automatic wait_period(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk_top);
      if (period_top) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Starts in a period_top cycle, ends in the next one; optionally taps rest mid-period.
  task automatic measure(input int inject_at, output int highs, output int gap);
    highs = int'(pwm_top[0]);
    gap   = 0;
    for (int i = 1; i < 1100; i++) begin
      @(negedge clk_top);
      if (i == inject_at)     rest_top = 1'b0;
      if (i == inject_at + 6) rest_top = 1'b1;
      if (period_top) begin
        gap = i;
        break;
      end
      highs += int'(pwm_top[0]);
    end
  endtask

  initial begin
    int r0;
    int highs;
    int gap;
    bit ok;

    vecs[0]  = mk(1,   37,   0, 0,   2);
    vecs[1]  = mk(1,   21,   0, 0,   0);
    vecs[2]  = mk(3,   21,   0, 0,   0);
    vecs[3]  = mk(2,    5,   0, 1,   0);
    vecs[4]  = mk(2,    5,   0, 2,   0);
    vecs[5]  = mk(0,   69,   5, 2,   5);
    vecs[6]  = mk(2,    5,   0, 3,   0);
    vecs[7]  = mk(2,    5,   0, 0,   0);
    vecs[8]  = mk(2,    5,   0, 1,   0);
    vecs[9]  = mk(2,    5,   5, 2,   0);
    vecs[10] = mk(2,   21,   0, 0,   0);
    vecs[11] = mk(0, 4101, 255, 0, 255);
    vecs[12] = mk(0,   21, 255, 0,   0);
    vecs[13] = mk(1, 3029,  65, 0, 190);

    @(posedge clk_top);
    #1 rst_top = 1'b0;
    @(negedge clk_top);
    check("reset pwm_top",    pwm_top,    0);
    check("reset sel_chan",   sel_chan,   0);
    check("reset duty_sel",   duty_sel,   0);
    check("reset rdy_top",    rdy_top,    0);
    check("reset period_top", period_top, 0);

    r0 = rdy_total;
    press(0, 3);
    repeat (30) @(negedge clk_top);
    check("glitch duty_sel", duty_sel, 0);
    check("glitch rdy",      rdy_total - r0, 0);

    // Press timing: first step visible after edge 7, repeat step after edge 23.
    r0 = rdy_total;
    @(posedge clk_top);
    #1 sum_top = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk_top);
      if (k == 20) #1 sum_top = 1'b1;
      @(negedge clk_top);
      case (k)
        6:  check("duty before first fire", duty_sel, 0);
        7:  begin
              check("duty first fire", duty_sel, 1);
              check("rdy same cycle as write", rdy_top, 0);
            end
        8:  check("rdy one clock after write", rdy_top, 1);
        22: check("duty before repeat", duty_sel, 1);
        23: check("duty after repeat", duty_sel, 2);
        default: ;
      endcase
    end
    repeat (30) @(negedge clk_top);
    check("hold rdy pulses", rdy_total - r0, 2);

    for (int v = 0; v < 14; v++) begin
      r0 = rdy_total;
      press(vecs[v].btn, vecs[v].hold);
      repeat (30) @(negedge clk_top);
      check($sformatf("vec%0d duty_sel", v), duty_sel,       vecs[v].exp_duty);
      check($sformatf("vec%0d sel_chan", v), sel_chan,       vecs[v].exp_sel);
      check($sformatf("vec%0d rdy",      v), rdy_total - r0, vecs[v].exp_rdy);
    end

    // Edge mode, ch0 at 65, then dropped to 64 mid-period.
    wait_period(ok);
    check("period_top seen", ok, 1);
    measure(-1, highs, gap);
    check("edge65 highs", highs, 130);
    check("edge65 gap",   gap,   512);
    r0 = rdy_total;
    measure(100, highs, gap);
    check("mid-change highs", highs, 130);
    check("mid-change gap",   gap,   512);
    check("mid-change duty",  duty_sel, 64);
    check("mid-change rdy",   rdy_total - r0, 1);
    measure(-1, highs, gap);
    check("edge64 highs", highs, 128);
    check("edge64 gap",   gap,   512);

    // Mode switch in the middle of a period takes effect at the next period start.
    mode_top = 1'b1;
    measure(-1, highs, gap);
    check("mode pending highs", highs, 128);
    check("mode pending gap",   gap,   512);
    measure(-1, highs, gap);
    check("center first gap", gap, 1020);
    measure(-1, highs, gap);
    check("center64 highs", highs, 254);
    check("center64 gap",   gap,   1020);

    // Reset in the middle of a press that is about to fire.
    press(2, 5);
    repeat (30) @(negedge clk_top);
    check("pre-reset sel_chan", sel_chan, 1);
    r0 = rdy_total;
    @(posedge clk_top);
    #1 sum_top = 1'b0;
    repeat (6) @(posedge clk_top);
    #1;
    rst_top = 1'b1;
    sum_top = 1'b1;
    @(posedge clk_top);
    #1 rst_top = 1'b0;
    @(negedge clk_top);
    check("midpress reset pwm_top",  pwm_top,  0);
    check("midpress reset sel_chan", sel_chan, 0);
    check("midpress reset duty_sel", duty_sel, 0);
    check("midpress reset rdy_top",  rdy_top,  0);
    repeat (40) @(negedge clk_top);
    check("no residual duty", duty_sel, 0);
    check("no residual sel",  sel_chan, 0);
    check("no residual rdy",  rdy_total - r0, 0);
    check("no residual pwm",  pwm_top, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
